// File: rtl/shft_deser_if.sv
// rtl/shft_deser_if.sv - serial input and parallel handshake bundle for shft_deser
interface shft_deser_if #(
    parameter int WIDTH = 3
);
    logic             sin;
    logic             sin_en;
    logic             frame;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             parity_err;

    // master: the deserializer itself; slave: serial source plus word consumer
    modport master (
        input  sin, sin_en, frame, dout_ready,
        output dout, dout_valid, overrun, parity_err
    );

    modport slave (
        output sin, sin_en, frame, dout_ready,
        input  dout, dout_valid, overrun, parity_err
    );
endinterface

// File: rtl/shft_deser.sv
// rtl/shft_deser.sv - MSB-first serial-in parallel-out receiver; optional even parity via SHFT_DESER_PARITY_EN
module shft_deser #(
    parameter int WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst,
    shft_deser_if.master  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SHFT_DESER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    logic [1:0]       state, state_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [WIDTH-1:0] shifted, first;
    logic [WIDTH-1:0] word;
    logic             word_par;
    logic             complete;
    logic             start;

    assign start = bus.sin_en & bus.frame;

    always_comb begin
        shifted    = sr << 1;
        shifted[0] = bus.sin;
        first      = '0;
        first[0]   = bus.sin;
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        sr_n     = sr;
        word     = sr;
        word_par = 1'b0;
        complete = 1'b0;
        if (start) begin
            // a frame strobe always restarts, discarding any partial word
            sr_n    = first;
            count_n = CW'(1);
`ifdef SHFT_DESER_PARITY_EN
            state_n = (WIDTH == 1) ? ST_PAR : ST_SHIFT;
`else
            if (WIDTH == 1) begin
                complete = 1'b1;
                word     = first;
                state_n  = ST_IDLE;
                count_n  = '0;
            end else begin
                state_n = ST_SHIFT;
            end
`endif
        end else if (bus.sin_en) begin
            case (state)
                ST_SHIFT: begin
                    sr_n    = shifted;
                    count_n = count + 1'b1;
                    if (count == LAST) begin
`ifdef SHFT_DESER_PARITY_EN
                        state_n = ST_PAR;
`else
                        complete = 1'b1;
                        word     = shifted;
                        state_n  = ST_IDLE;
                        count_n  = '0;
`endif
                    end
                end
`ifdef SHFT_DESER_PARITY_EN
                ST_PAR: begin
                    complete = 1'b1;
                    word     = sr;
                    word_par = (^sr) ^ bus.sin;
                    state_n  = ST_IDLE;
                    count_n  = '0;
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            count <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            sr    <= sr_n;
        end
    end

    // the holding register reloads only when empty or being drained this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.parity_err <= 1'b0;
        end else begin
            bus.overrun <= 1'b0;
            if (complete) begin
                if (!bus.dout_valid || bus.dout_ready) begin
                    bus.dout       <= word;
                    bus.parity_err <= word_par;
                    bus.dout_valid <= 1'b1;
                end else begin
                    bus.overrun <= 1'b1;
                end
            end else if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shft_deser.sv
// tb/tb_shft_deser.sv - directed self-checking bench for shft_deser (WIDTH=3)
module tb_shft_deser;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    shft_deser_if #(.WIDTH(W)) bus ();

    shft_deser #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // apply one cycle of inputs, then settle just after the rising edge
    task automatic step(input logic f, input logic s, input logic e, input logic r);
        bus.frame      = f;
        bus.sin        = s;
        bus.sin_en     = e;
        bus.dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.frame = 0; bus.sin = 0; bus.sin_en = 0; bus.dout_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        chk("rst_parity", 32'(bus.parity_err), 0);
        rst = 1'b0;

`ifndef SHFT_DESER_PARITY_EN
        // basic word 101
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("basic_not_yet", 32'(bus.dout_valid), 0);
        step(0, 1, 1, 0);
        chk("basic_dout", 32'(bus.dout), 32'h5);
        chk("basic_valid", 32'(bus.dout_valid), 1);
        chk("basic_overrun", 32'(bus.overrun), 0);
        step(0, 0, 0, 1);
        chk("basic_drain", 32'(bus.dout_valid), 0);

        // stall two cycles between bits 2 and 3, with a stray frame
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("stall_1", 32'(bus.dout_valid), 0);
        step(0, 0, 0, 0);
        chk("stall_2", 32'(bus.dout_valid), 0);
        step(0, 1, 1, 0);
        chk("stall_dout", 32'(bus.dout), 32'h5);
        chk("stall_valid", 32'(bus.dout_valid), 1);

        // overrun: 011 arrives while 101 is still held
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("ovr_pre", 32'(bus.overrun), 0);
        step(0, 1, 1, 0);
        chk("ovr_pulse", 32'(bus.overrun), 1);
        chk("ovr_dout", 32'(bus.dout), 32'h5);
        chk("ovr_valid", 32'(bus.dout_valid), 1);
        step(0, 0, 0, 0);
        chk("ovr_one_cycle", 32'(bus.overrun), 0);
        step(0, 0, 0, 1);
        chk("ovr_drain", 32'(bus.dout_valid), 0);

        // simultaneous completion and hand-off
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("sim_first", 32'(bus.dout), 32'h5);
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 1);
        chk("sim_dout", 32'(bus.dout), 32'h6);
        chk("sim_valid", 32'(bus.dout_valid), 1);
        chk("sim_overrun", 32'(bus.overrun), 0);
        step(0, 0, 0, 1);
        chk("sim_drain", 32'(bus.dout_valid), 0);

        // resync discards 1,1 and restarts with 0,0,1
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(1, 0, 1, 0);
        chk("resync_early", 32'(bus.dout_valid), 0);
        step(0, 0, 1, 0);
        chk("resync_overrun", 32'(bus.overrun), 0);
        step(0, 1, 1, 0);
        chk("resync_dout", 32'(bus.dout), 32'h1);
        chk("resync_valid", 32'(bus.dout_valid), 1);

        // asynchronous reset mid-word while a word is held
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", 32'(bus.dout), 0);
        chk("arst_valid", 32'(bus.dout_valid), 0);
        chk("arst_overrun", 32'(bus.overrun), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(0, 1, 1, 0);
        chk("arst_partial_gone", 32'(bus.dout_valid), 0);
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("post_rst_dout", 32'(bus.dout), 32'h6);
        chk("post_rst_valid", 32'(bus.dout_valid), 1);
        chk("post_rst_parity", 32'(bus.parity_err), 0);
`else
        // 101 with even parity bit 0
        step(1, 1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        chk("par_wait", 32'(bus.dout_valid), 0);
        step(0, 0, 1, 0);
        chk("par_dout_a", 32'(bus.dout), 32'h5);
        chk("par_valid_a", 32'(bus.dout_valid), 1);
        chk("par_err_a", 32'(bus.parity_err), 0);
        step(0, 0, 0, 1);
        chk("par_drain", 32'(bus.dout_valid), 0);
        // 111 with parity bit 0 is a parity error but still delivered
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        chk("par_dout_b", 32'(bus.dout), 32'h7);
        chk("par_valid_b", 32'(bus.dout_valid), 1);
        chk("par_err_b", 32'(bus.parity_err), 1);
        chk("par_overrun", 32'(bus.overrun), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shft_deser.md
# shft_deser

Serial-in, parallel-out receiver for the MSB-first bit stream emitted by the team's parallel-load shift register. It collects `WIDTH` bits framed by a start strobe, qualified by a shift enable, and presents each word on a registered parallel output with a valid/ready handshake. A one-word holding register lets the next word shift in while the consumer drains the current one.

## Interface
- `WIDTH`, default 3: data bits per word, minimum 1.
- `clk  input  1  single clock; all state updates on rising edge`
- `rst  input  1  asynchronous, active-high reset`
- `sin  input  1  serial data bit, sampled when sin_en=1`
- `sin_en  input  1  shift enable (the serial side's save/clock-enable); sin and frame are ignored when 0`
- `frame  input  1  start strobe; high together with the first (MSB) bit of a word`
- `dout  output  WIDTH  received word, bit WIDTH-1 = first bit received`
- `dout_valid  output  1  dout holds an unconsumed word`
- `dout_ready  input  1  consumer accepts dout on a cycle where dout_valid=1`
- `overrun  output  1  one-cycle pulse: a completed word was dropped`
- `parity_err  output  1  parity result for the word in dout (see Configuration)`

One clock; reset is asynchronous and active-high.

## Operation
- States: IDLE, SHIFT, PAR (PAR exists only with the parity macro).
- IDLE: on `sin_en & frame`, load `sin` as the MSB and set count=1. The next state is SHIFT, or completion when WIDTH=1.
- SHIFT: on each `sin_en` cycle, shift left, insert `sin` at the LSB and increment count. When `sin_en`=0, state, count and shift contents hold.
- Completion occurs on the edge that samples bit WIDTH (or the parity bit in PAR). That edge loads `dout` with the assembled word, including the bit sampled on that edge, and returns the FSM to IDLE.
- Resync: `sin_en & frame` in SHIFT or PAR discards the partial word, restarts with the current bit as the MSB and sets count=1. No overrun is raised.
- A `frame` without `sin_en` has no effect.
- Handshake:
  - `dout_valid` clears on the edge where `dout_valid & dout_ready`, unless a completion occurs on the same edge.
  - If completion and a hand-off occur on the same edge, the new word loads and `dout_valid` stays 1.
  - If completion occurs while `dout_valid=1 & dout_ready=0`, the new word is dropped, `dout` and `parity_err` are unchanged, and `overrun` pulses for one cycle.
- `dout` is stable whenever `dout_valid=1` and no accepted reload occurs.

## Timing
- Reset values: state=IDLE, count=0, shift register=0, `dout`=0, `dout_valid`=0, `overrun`=0, `parity_err`=0.
- Reset mid-word discards all state immediately, with no output glitch beyond the asynchronous clear.
- Latency: `dout_valid` is high in the cycle after the edge that samples the last bit (0 extra cycles of pipeline).
- With back-to-back words and sin_en held at 1, one word completes every WIDTH cycles, or WIDTH+1 with parity. Sustained throughput without overrun needs `dout_ready` at least once per word period.
- `overrun` is registered and high for exactly one cycle per dropped word.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `SHFT_DESER_PARITY_EN`.
- Defined:
  - One extra bit follows the LSB, sampled in the PAR state. Even parity is used.
  - `parity_err` = XOR of the WIDTH data bits and the parity bit.
  - `parity_err` loads with `dout` and is valid while `dout_valid`=1.
  - The word is delivered even when `parity_err`=1.
- Undefined: the PAR state is absent, completion occurs on bit WIDTH, and `parity_err` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then WIDTH=3, no parity: frame+sin=1, then sin=0, then sin=1, with sin_en=1 throughout. Required: dout=3'b101 and dout_valid=1 in the cycle after the third edge, overrun=0.
- Stall: same word with sin_en=0 for 2 cycles between bits 2 and 3. Required: still 3'b101, with completion delayed by exactly 2 cycles. A frame pulse during the stall is ignored.
- Overrun: hold dout_ready=0 and send 101, then 011. Required: dout stays 3'b101 and overrun pulses once. Then dout_ready=1 for one cycle gives dout_valid=0.
- Simultaneous: dout_ready=1 on the completion edge of a second word 110. Required: dout=3'b110, dout_valid stays 1, overrun=0.
- Resync and reset: send frame+1, 1, then frame+0, 0, 1. Required: dout=3'b001. Asserting rst mid-word gives all outputs 0 immediately, and the next full word is received correctly.
- With SHFT_DESER_PARITY_EN, WIDTH=3: send 101 with parity 0, giving parity_err=0. Then send 111 with parity 0, giving dout=3'b111 and parity_err=1.
